modred_sched: RTL and testbench

//  Round-robin scheduler that shares one secp256k1 ModRed reduction unit (512b -> 256b, level-start/busy iface)

---
 rtl/ecpa_pkg.sv | 23 ++
 rtl/rr_pick.sv | 27 ++
 rtl/modred_sched.sv | 152 +++++++++++++++
 tb/tb_modred_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ecpa_pkg.sv
// rtl/ecpa_pkg.sv - secp256k1 constants, ModRed widths and scheduler state encoding
package ecpa_pkg;
   localparam int MR_IN_W  = 512;
   localparam int MR_OUT_W = 256;
   localparam logic [MR_OUT_W-1:0] SECP_P =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      SUB   = 3'd4,
      RESP  = 3'd5
   } sched_state_t;

   // ModRed output lies in [0, 2P); one conditional subtract lands it in [0, P).
   function automatic logic [MR_OUT_W-1:0] final_sub(input logic [MR_OUT_W-1:0] b);
      logic [MR_OUT_W:0] d;
      d = {1'b0, b} - {1'b0, SECP_P};
      return d[MR_OUT_W] ? b : d[MR_OUT_W-1:0];
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at/after ptr
module rr_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         any
);
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = (int'(ptr) + i) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = W'(j);
         end
      end
   end
endmodule

// File: rtl/modred_sched.sv
// rtl/modred_sched.sv - round-robin sharing of one secp256k1 ModRed unit among N_REQ requesters
// Single outstanding op; optional final conditional subtract; timeout abort returns rsp_err.
module modred_sched
   import ecpa_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int FINAL_SUB   = 1,
   parameter int TIMEOUT_CYC = 64,
   localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*MR_IN_W-1:0] req_a,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [MR_OUT_W-1:0]      rsp_data,
   output logic                     rsp_err,
   output logic                     mr_start,
   output logic [MR_IN_W-1:0]       mr_a,
   input  logic                     mr_busy,
   input  logic [MR_OUT_W-1:0]      mr_b
);
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   sched_state_t          state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                  mr_start_q, mr_start_d;
   logic [MR_IN_W-1:0]    mr_a_q, mr_a_d;
   logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
   logic [MR_OUT_W-1:0]   rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [MR_OUT_W-1:0]   b_q, b_d;
   logic                  seen_busy_q, seen_busy_d;
   logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

   logic [N_REQ-1:0]      pick_gnt;
   logic [ID_W-1:0]       pick_idx;
   logic                  pick_any;

   rr_pick #(.N(N_REQ), .W(ID_W)) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      mr_start_d  = mr_start_q;
      mr_a_d      = mr_a_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      b_d         = b_q;
      seen_busy_d = seen_busy_q;
      tmo_cnt_d   = tmo_cnt_q;
      case (state_q)
         IDLE: begin
            mr_start_d = 1'b0;
            if (|req_valid) state_d = GRANT;
         end
         GRANT: begin
            if (pick_any) begin
               mr_a_d   = req_a[MR_IN_W*pick_idx +: MR_IN_W];
               rsp_id_d = pick_idx;
               rr_ptr_d = (pick_idx == ID_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
               state_d  = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            mr_start_d  = 1'b1;
            tmo_cnt_d   = '0;
            seen_busy_d = 1'b0;
            state_d     = RUN;
         end
         RUN: begin
            if (mr_busy) seen_busy_d = 1'b1;
            // busy=0 before any busy=1 is ModRed's Init cycle, not completion
            if (seen_busy_q && !mr_busy) begin
               mr_start_d = 1'b0;
               rsp_err_d  = 1'b0;
               if (FINAL_SUB != 0) begin
                  b_d     = mr_b;
                  state_d = SUB;
               end else begin
                  rsp_data_d = mr_b;
                  state_d    = RESP;
               end
            end else if (tmo_cnt_q == TW'(TIMEOUT_CYC-1)) begin
               mr_start_d = 1'b0;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
               state_d    = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         SUB: begin
            rsp_data_d = final_sub(b_q);
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_err_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         mr_start_q  <= 1'b0;
         mr_a_q      <= '0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         b_q         <= '0;
         seen_busy_q <= 1'b0;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         mr_start_q  <= mr_start_d;
         mr_a_q      <= mr_a_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         b_q         <= b_d;
         seen_busy_q <= seen_busy_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

   assign req_ready = (state_q == GRANT && pick_any) ? pick_gnt : '0;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign mr_start  = mr_start_q;
   assign mr_a      = mr_a_q;
endmodule

// File: tb/tb_modred_sched.sv
// tb/tb_modred_sched.sv - directed bench for modred_sched with FINAL_SUB=1 and FINAL_SUB=0 in lockstep
// Behavioural ModRed model per instance: Init cycle, 4 busy cycles, then result (or busy forever when stuck).
module tb_modred_sched;
   import ecpa_pkg::*;

   localparam int N   = 4;
   localparam int TMO = 64;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N-1:0]         req_valid;
   logic [N*512-1:0]     req_a;
   logic                 rsp_ready;
   logic [1:0][N-1:0]    req_ready;
   logic [1:0]           rsp_valid;
   logic [1:0][1:0]      rsp_id;
   logic [1:0][255:0]    rsp_data;
   logic [1:0]           rsp_err;
   logic [1:0]           mr_start;
   logic [1:0][511:0]    mr_a;
   logic [1:0]           mr_busy = '0;
   logic [1:0][255:0]    mr_b = '0;
   logic                 stuck;
   int                   mcnt [2];
   int                   checks = 0;
   int                   failures = 0;

   always #5 clk = ~clk;

   modred_sched #(.N_REQ(N), .FINAL_SUB(1), .TIMEOUT_CYC(TMO)) u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_id(rsp_id[0]), .rsp_data(rsp_data[0]),
      .rsp_err(rsp_err[0]), .mr_start(mr_start[0]), .mr_a(mr_a[0]), .mr_busy(mr_busy[0]), .mr_b(mr_b[0])
   );

   modred_sched #(.N_REQ(N), .FINAL_SUB(0), .TIMEOUT_CYC(TMO)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_id(rsp_id[1]), .rsp_data(rsp_data[1]),
      .rsp_err(rsp_err[1]), .mr_start(mr_start[1]), .mr_a(mr_a[1]), .mr_busy(mr_busy[1]), .mr_b(mr_b[1])
   );

   function automatic logic [255:0] red(input logic [511:0] a);
      logic [511:0] t, t2;
      t  = 512'(a[511:256]) * 512'h1000003D1 + 512'(a[255:0]);
      t2 = 512'(t[511:256]) * 512'h1000003D1 + 512'(t[255:0]);
      return t2[255:0];
   endfunction

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!mr_start[g]) begin
            mcnt[g]    <= 0;
            mr_busy[g] <= 1'b0;
         end else begin
            mcnt[g] <= mcnt[g] + 1;
            if (mcnt[g] >= 1 && (mcnt[g] <= 4 || stuck)) begin
               mr_busy[g] <= 1'b1;
            end else if (mcnt[g] == 5) begin
               mr_busy[g] <= 1'b0;
               mr_b[g]    <= red(mr_a[g]);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_grant(input string tag, input logic [N-1:0] exp);
      int n = 0;
      while (req_ready[0] == '0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_u0"}, req_ready[0], exp);
      check({tag, "_u1"}, req_ready[1], exp);
      @(negedge clk);
   endtask

   task automatic collect(input string tag, input logic [1:0] id, input logic [255:0] d0,
                          input logic [255:0] d1, input logic err);
      int n = 0;
      while (!rsp_valid[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_v0"},   rsp_valid[0], 1'b1);
      check({tag, "_id0"},  rsp_id[0],    id);
      check({tag, "_d0"},   rsp_data[0],  d0);
      check({tag, "_err0"}, rsp_err[0],   err);
      check({tag, "_v1"},   rsp_valid[1], 1'b1);
      check({tag, "_id1"},  rsp_id[1],    id);
      check({tag, "_d1"},   rsp_data[1],  d1);
      check({tag, "_err1"}, rsp_err[1],   err);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_drop"}, rsp_valid[0], 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [511:0] a;
      int n, l0, l1, seen;

      rst_n = 1'b0;
      req_valid = 4'hF;
      req_a = '0;
      rsp_ready = 1'b0;
      stuck = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready",  req_ready[0], 4'h0);
      check("rst_valid",  rsp_valid[0], 1'b0);
      check("rst_id",     rsp_id[0],    2'd0);
      check("rst_data",   rsp_data[0],  256'd0);
      check("rst_err",    rsp_err[0],   1'b0);
      check("rst_start",  mr_start[0],  1'b0);
      check("rst_mra",    mr_a[0][255:0], 256'd0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rel_ready", req_ready[0], 4'h0);
      check("rel_start", mr_start[0],  1'b0);

      // A = 2^256 folds to 2^32 + 977
      a = '0;
      a[256] = 1'b1;
      req_a[0 +: 512] = a;
      req_valid = 4'b0001;
      wait_grant("t2_gnt", 4'b0001);
      req_valid = '0;
      n = 0;
      while (!mr_busy[0] && n < 50) begin @(negedge clk); n++; end
      while (mr_busy[0] && n < 100) begin @(negedge clk); n++; end
      l0 = -1;
      l1 = -1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (rsp_valid[0] && l0 < 0) l0 = k;
         if (rsp_valid[1] && l1 < 0) l1 = k;
      end
      check("t2_lat_sub",   l0, 2);
      check("t2_lat_nosub", l1, 1);
      collect("t2", 2'd0, 256'h1_000003D1, 256'h1_000003D1, 1'b0);

      a = '0;
      a[255:0] = SECP_P;
      req_a[3*512 +: 512] = a;
      req_valid = 4'b1000;
      wait_grant("t3_gnt", 4'b1000);
      req_valid = '0;
      collect("t3", 2'd3, 256'd0, SECP_P, 1'b0);

      for (int i = 0; i < N; i++) req_a[i*512 +: 512] = 512'(i);
      req_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         wait_grant($sformatf("t4_gnt%0d", k), 4'(1 << (k % 4)));
         collect($sformatf("t4_%0d", k), 2'(k % 4), 256'(k % 4), 256'(k % 4), 1'b0);
      end

      wait_grant("t5_gnt", 4'b0010);
      n = 0;
      while (!rsp_valid[0] && n < 200) begin @(negedge clk); n++; end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("t5_v%0d", c),     rsp_valid[0], 1'b1);
         check($sformatf("t5_id%0d", c),    rsp_id[0],    2'd1);
         check($sformatf("t5_d%0d", c),     rsp_data[0],  256'd1);
         check($sformatf("t5_rdy%0d", c),   req_ready[0], 4'h0);
         check($sformatf("t5_start%0d", c), mr_start[0],  1'b0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      wait_grant("t5_next", 4'b0100);
      collect("t5b", 2'd2, 256'd2, 256'd2, 1'b0);
      req_valid = '0;
      repeat (2) @(negedge clk);

      req_a[0 +: 512] = 512'd5;
      req_valid = 4'b0001;
      wait_grant("t6_gnt", 4'b0001);
      req_valid = '0;
      n = 0;
      while (!mr_start[0] && n < 20) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check("t6_run", mr_start[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_async_start0", mr_start[0], 1'b0);
      check("t6_async_start1", mr_start[1], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid[0] || rsp_valid[1] || mr_start[0]) seen++;
      end
      check("t6_no_rsp", seen, 0);

      stuck = 1'b1;
      req_a[1*512 +: 512] = 512'd7;
      req_valid = 4'b0010;
      wait_grant("t6_tmo_gnt", 4'b0010);
      req_valid = '0;
      n = 0;
      while (!mr_start[0] && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (mr_start[0] && n < 200) begin @(negedge clk); n++; end
      check("t6_run_cycles", n, TMO);
      collect("t6_tmo", 2'd1, 256'd0, 256'd0, 1'b1);
      check("t6_err_clr", rsp_err[0], 1'b0);
      stuck = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
